// File: rtl/play_stream_engine_if.sv
// Bundle of control, SDRAM-read and audio-stream signals for play_stream_engine.
// play_loop exists only when PLAY_STREAM_LOOP_EN is defined.
interface play_stream_engine_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  logic              play_start;
  logic [ADDR_W-1:0] play_select;
  logic              play_pause;
  logic              play_stop;
  logic              play_done;
  logic              play_busy;
  logic              play_read;
  logic [ADDR_W-1:0] play_addr;
  logic [DATA_W-1:0] play_readdata;
  logic              play_sdram_finished;
  logic              play_audio_valid;
  logic [DATA_W-1:0] play_audio_data;
  logic              play_audio_ready;
`ifdef PLAY_STREAM_LOOP_EN
  logic              play_loop;

  modport master (
    input  play_start, play_select, play_pause, play_stop, play_loop,
           play_readdata, play_sdram_finished, play_audio_ready,
    output play_done, play_busy, play_read, play_addr,
           play_audio_valid, play_audio_data
  );

  modport slave (
    output play_start, play_select, play_pause, play_stop, play_loop,
           play_readdata, play_sdram_finished, play_audio_ready,
    input  play_done, play_busy, play_read, play_addr,
           play_audio_valid, play_audio_data
  );
`else
  modport master (
    input  play_start, play_select, play_pause, play_stop,
           play_readdata, play_sdram_finished, play_audio_ready,
    output play_done, play_busy, play_read, play_addr,
           play_audio_valid, play_audio_data
  );

  modport slave (
    output play_start, play_select, play_pause, play_stop,
           play_readdata, play_sdram_finished, play_audio_ready,
    input  play_done, play_busy, play_read, play_addr,
           play_audio_valid, play_audio_data
  );
`endif
endinterface

// File: rtl/play_stream_engine.sv
// Streams a length-prefixed recording from SDRAM through a prefetch FIFO to the
// audio sink. Defining PLAY_STREAM_LOOP_EN adds the play_loop replay input.
module play_stream_engine #(
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic                  i_clk,
  input logic                  i_rst,
  play_stream_engine_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] READ_LEN = 3'd1;
  localparam logic [2:0] STREAM   = 3'd2;
  localparam logic [2:0] FINISH   = 3'd3;
  localparam logic [2:0] ABORT    = 3'd4;

  logic [2:0]        state;
  logic              hdr_phase;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] fetch_ptr;
  logic [ADDR_W-1:0] fetch_left;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W-1:0] hdr_len;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              read_req;
  logic              read_done;
  logic              outstanding;
  logic              audio_valid;
  logic              push;
  logic              pop;
  logic              flush;
  logic              last_pop;
  logic              loop_req;

`ifdef PLAY_STREAM_LOOP_EN
  assign loop_req = bus.play_loop;
`else
  assign loop_req = 1'b0;
`endif

  // Any set bit above the address field means the length cannot be represented.
  assign hdr_len = (|(bus.play_readdata >> ADDR_W)) ? '1 : bus.play_readdata[ADDR_W-1:0];

  always_comb begin
    read_req = 1'b0;
    case (state)
      READ_LEN, ABORT: read_req = 1'b1;
      STREAM:          read_req = (fetch_left != '0) && (count != FULL_CNT);
      default:         read_req = 1'b0;
    endcase
  end

  assign read_done   = read_req && bus.play_sdram_finished;
  assign outstanding = read_req && !bus.play_sdram_finished;
  assign audio_valid = (state == STREAM) && (count != '0) && !bus.play_pause && !bus.play_stop;
  assign push        = (state == STREAM) && read_done && !bus.play_stop;
  assign pop         = audio_valid && bus.play_audio_ready;
  assign last_pop    = pop && (remaining == ADDR_W'(1));
  assign flush       = bus.play_stop && ((state == READ_LEN) || (state == STREAM));

  assign bus.play_read        = read_req;
  assign bus.play_addr        = read_req ? (hdr_phase ? base : fetch_ptr) : '0;
  assign bus.play_busy        = (state != IDLE);
  assign bus.play_done        = (state == FINISH);
  assign bus.play_audio_valid = audio_valid;
  assign bus.play_audio_data  = (count != '0) ? fifo_mem[rd_ptr] : '0;

  // An outstanding read on stop must still see its strobe, so it detours via ABORT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      hdr_phase  <= 1'b0;
      base       <= '0;
      fetch_ptr  <= '0;
      fetch_left <= '0;
      remaining  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.play_start && !bus.play_stop) begin
            base      <= bus.play_select;
            hdr_phase <= 1'b1;
            state     <= READ_LEN;
          end
        end
        READ_LEN: begin
          if (bus.play_stop) begin
            state <= outstanding ? ABORT : FINISH;
          end else if (read_done) begin
            if (hdr_len == '0) begin
              state <= FINISH;
            end else begin
              hdr_phase  <= 1'b0;
              fetch_ptr  <= base + ADDR_W'(1);
              fetch_left <= hdr_len;
              remaining  <= hdr_len;
              state      <= STREAM;
            end
          end
        end
        STREAM: begin
          if (bus.play_stop) begin
            state <= outstanding ? ABORT : FINISH;
          end else begin
            if (push) begin
              fetch_ptr  <= fetch_ptr + ADDR_W'(1);
              fetch_left <= fetch_left - ADDR_W'(1);
            end
            if (pop) begin
              remaining <= remaining - ADDR_W'(1);
            end
            if (last_pop) begin
              if (loop_req) begin
                hdr_phase <= 1'b1;
                state     <= READ_LEN;
              end else begin
                state <= FINISH;
              end
            end
          end
        end
        ABORT: begin
          if (bus.play_sdram_finished) begin
            state <= FINISH;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bus.play_readdata;
    end
  end
endmodule
